// File: rtl/scan_loader_pkg.sv
// Shared types and constants for the scan memory loader: FSM states, region
// encoding, default geometry and the address range rule.
package scan_loader_pkg;

    localparam int ADDR_W_DEF     = 16;
    localparam int DATA_W_DEF     = 16;
    localparam int DMEM_DEPTH_DEF = 1024;
    localparam int CMEM_DEPTH_DEF = 128;

    localparam logic REGION_DMEM = 1'b0;
    localparam logic REGION_CMEM = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RDCAP,
        ST_SHOUT,
        ST_EXEC,
        ST_DONE
    } state_t;

    // An offset is legal only if it lands inside the selected macro.
    function automatic logic addr_in_range(input logic region, input int offset,
                                           input int dmem_depth, input int cmem_depth);
        return (region == REGION_CMEM) ? (offset < cmem_depth) : (offset < dmem_depth);
    endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Serial-in/parallel-out shift register with parallel load; the MSB of q is
// the serial output. Load takes priority over shift.
module scan_shift_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift_en,
    input  logic         serial_in,
    input  logic         load_en,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (load_en)
            q <= load_data;
        else if (shift_en)
            q <= {q[W-2:0], serial_in};
    end

endmodule

// File: rtl/scan_mem_loader.sv
// Bit-serial scan front end: shifts in address/data, issues single SRAM
// accesses, shifts read data back out and runs the fabric exec handshake.
// Optional parity on the data word: define SCAN_MEM_LOADER_PARITY_EN.
module scan_mem_loader
    import scan_loader_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DMEM_DEPTH = DMEM_DEPTH_DEF,
    parameter int CMEM_DEPTH = CMEM_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_en,
    input  logic              scan_in,
    input  logic              scan_data_or_addr,
    input  logic              read_write,
    input  logic              scan_commit,
    output logic              scan_out,
    input  logic              scan_start_exec,
    output logic              exec_end,
    output logic              busy,
    output logic              err,
    output logic              mem_sel,
    output logic [ADDR_W-2:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fabric_start,
    input  logic              fabric_done
);

`ifdef SCAN_MEM_LOADER_PARITY_EN
    localparam int DREG_W = DATA_W + 1;
`else
    localparam int DREG_W = DATA_W;
`endif
    localparam int CNT_W = $clog2(DREG_W);

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DREG_W-1:0]   data_q;
    logic [DREG_W-1:0]   rb_q;
    logic [DREG_W-1:0]   rb_load;
    logic [CNT_W-1:0]    shout_cnt;
    logic                start_q;
    logic                start_rise;
    logic                par_ok;
    logic                in_range;
    logic                shift_ok;

`ifdef SCAN_MEM_LOADER_PARITY_EN
    // Even parity: data bits plus the trailing parity bit XOR to zero.
    assign par_ok    = ~^data_q;
    assign mem_wdata = data_q[DREG_W-1:1];
    assign rb_load   = {mem_rdata, ^mem_rdata};
`else
    assign par_ok    = 1'b1;
    assign mem_wdata = data_q;
    assign rb_load   = mem_rdata;
`endif

    assign shift_ok   = (state == ST_IDLE) && scan_en;
    assign mem_sel    = addr_q[ADDR_W-1];
    assign mem_addr   = addr_q[ADDR_W-2:0];
    assign in_range   = addr_in_range(mem_sel, 32'(mem_addr), DMEM_DEPTH, CMEM_DEPTH);
    assign start_rise = scan_start_exec && !start_q;
    assign busy       = (state != ST_IDLE);
    assign scan_out   = (state == ST_SHOUT) && rb_q[DREG_W-1];

    scan_shift_reg #(.W(ADDR_W)) u_addr_reg (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (shift_ok && !scan_data_or_addr),
        .serial_in (scan_in),
        .load_en   (1'b0),
        .load_data ('0),
        .q         (addr_q)
    );

    scan_shift_reg #(.W(DREG_W)) u_data_reg (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (shift_ok && scan_data_or_addr),
        .serial_in (scan_in),
        .load_en   (1'b0),
        .load_data ('0),
        .q         (data_q)
    );

    // NOTE: the read-back register is reset with everything else so scan_out
    // and parity never expose stale SRAM data after a reset.
    scan_shift_reg #(.W(DREG_W)) u_rb_reg (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (state == ST_SHOUT),
        .serial_in (1'b0),
        .load_en   (state == ST_RDCAP),
        .load_data (rb_load),
        .q         (rb_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            mem_we       <= 1'b0;
            mem_re       <= 1'b0;
            fabric_start <= 1'b0;
            exec_end     <= 1'b0;
            err          <= 1'b0;
            start_q      <= 1'b0;
            shout_cnt    <= '0;
        end else begin
            start_q      <= scan_start_exec;
            // NOTE: strobes default low each cycle so each one is a single-cycle pulse.
            mem_we       <= 1'b0;
            mem_re       <= 1'b0;
            fabric_start <= 1'b0;

            if (scan_commit && state != ST_IDLE)
                err <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (scan_commit) begin
                        // A commit consumes the cycle; a coincident start edge is lost.
                        if (!in_range || (read_write && !par_ok)) begin
                            err <= 1'b1;
                        end else if (read_write) begin
                            mem_we <= 1'b1;
                            state  <= ST_WRITE;
                        end else begin
                            mem_re <= 1'b1;
                            state  <= ST_READ;
                        end
                    end else if (start_rise) begin
                        fabric_start <= 1'b1;
                        state        <= ST_EXEC;
                    end
                end
                ST_WRITE: state <= ST_IDLE;
                ST_READ:  state <= ST_RDCAP;
                ST_RDCAP: begin
                    shout_cnt <= CNT_W'(DREG_W - 1);
                    state     <= ST_SHOUT;
                end
                ST_SHOUT: begin
                    if (shout_cnt == '0)
                        state <= ST_IDLE;
                    else
                        shout_cnt <= shout_cnt - CNT_W'(1);
                end
                ST_EXEC: begin
                    if (!scan_start_exec) begin
                        state <= ST_IDLE;
                    end else if (fabric_done) begin
                        exec_end <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!scan_start_exec) begin
                        exec_end <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/scan_mem_loader.md
Name: scan_mem_loader

Overview:
- Bit-serial scan front end of the SoC, sitting between the external scan pins and the on-chip CMEM/DMEM SRAM macros.
- Assembles scan-shifted address and data words and issues single-word SRAM writes or reads; read data shifts back out on scan_out.
- Sequences the execution handshake: scan_start_exec starts the fabric, fabric_done is returned to the pins as exec_end.

Parameters:
- ADDR_W, 16, scan address width; bit ADDR_W-1 selects region (0=DMEM, 1=CMEM)
- DATA_W, 16, SRAM word width for both regions
- DMEM_DEPTH, 1024, valid DMEM word count
- CMEM_DEPTH, 128, valid CMEM word count

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- scan_en  in  1  shift enable; one bit accepted per cycle while high
- scan_in  in  1  serial input bit, MSB first
- scan_data_or_addr  in  1  shift target: 0=address reg, 1=data reg
- read_write  in  1  commit type: 1=write, 0=read
- scan_commit  in  1  single-cycle pulse that launches the access
- scan_out  out  1  serial read-back bit, MSB first
- scan_start_exec  in  1  level; rising edge starts execution
- exec_end  out  1  execution-finished flag
- busy  out  1  access, read-back or exec in progress
- err  out  1  sticky error flag
- mem_sel  out  1  0=DMEM, 1=CMEM
- mem_addr  out  ADDR_W-1  word address
- mem_wdata  out  DATA_W  write data
- mem_we  out  1  write strobe
- mem_re  out  1  read strobe
- mem_rdata  in  DATA_W  read data, valid 1 cycle after mem_re
- fabric_start  out  1  one-cycle start pulse to the CGRA
- fabric_done  in  1  level from the CGRA

Behaviour:
- Reset: every output is 0; address, data and read-back registers are 0; FSM is in IDLE. Reset is effective mid-operation, and any in-flight access is abandoned with no strobe.
- Shift: in IDLE with scan_en=1, the selected register shifts left one bit per cycle, taking scan_in into the LSB. There is no bit counter; the last ADDR_W/DATA_W bits win. scan_en is ignored outside IDLE.
- FSM states: IDLE, WRITE, READ, RDCAP, SHOUT, EXEC, DONE.
- IDLE + scan_commit with read_write=1 goes to WRITE. mem_we=1 for exactly 1 cycle with the registered address and data, then back to IDLE.
- IDLE + scan_commit with read_write=0 goes to READ (mem_re=1, 1 cycle), then RDCAP (capture mem_rdata), then SHOUT.
- SHOUT presents the captured word MSB first on scan_out, one bit per cycle for DATA_W cycles, then returns to IDLE. scan_out is 0 outside SHOUT.
- Range check: the offset must be < DMEM_DEPTH, or < CMEM_DEPTH when mem_sel=1. An out-of-range commit sets err, suppresses mem_we/mem_re and stays in IDLE.
- scan_commit outside IDLE is ignored and sets err.
- Exec: a rising edge of scan_start_exec in IDLE gives fabric_start=1 for 1 cycle and enters EXEC.
  - When fabric_done=1 in EXEC, go to DONE with exec_end=1.
  - exec_end holds until scan_start_exec=0, then return to IDLE.
  - If scan_start_exec falls during EXEC, return to IDLE with no exec_end.
- Simultaneous scan_commit and start-exec edge in IDLE: the commit wins and the edge is dropped, since the edge detector is updated every cycle.
- busy = (state != IDLE).
- err clears only on reset.

Optional Feature:
- Macro: SCAN_MEM_LOADER_PARITY_EN.
- Enabled:
  - The data register is DATA_W+1 bits; the LSB is even parity over the data bits.
  - A write commit with a parity mismatch sets err and suppresses mem_we.
  - Read-back appends the computed parity as a final bit, so SHOUT lasts DATA_W+1 cycles.
- Disabled: no parity bit, and timing is as described in Behaviour.

Decomposition:
- Package scan_loader_pkg holds:
  - the FSM state enum;
  - region encoding constants REGION_DMEM and REGION_CMEM;
  - default width and depth localparams.
- One sub-module, scan_shift_reg, a parameterised serial-in/parallel-out register with parallel load and serial out. It is instantiated for address, data and read-back.

Test Plan:
- Write: shift address 0x0005 and data 0xBEEF, then commit with rw=1 → mem_we for 1 cycle, mem_sel=0, mem_addr=5, mem_wdata=0xBEEF, err=0.
- Readback: shift address 0x8010, commit with rw=0, mem_rdata=0x1234 → mem_sel=1, mem_addr=0x10, mem_re for 1 cycle, scan_out bits 0001001000110100 over 16 cycles starting 2 cycles after commit.
- Range: address 0x8080 (CMEM offset 128), commit with rw=1 → no mem_we, err=1; a second commit during SHOUT also leaves err=1 with no strobe.
- Exec: raise scan_start_exec → fabric_start for 1 cycle. Drive fabric_done high 50 cycles later → exec_end=1 next cycle, held until scan_start_exec=0, then busy=0.
- Reset: assert rst during SHOUT of read-back 0xFFFF → scan_out, busy and exec_end are 0 immediately (async), FSM in IDLE.
- Parity (macro on): write 0x0001 with parity bit 0 → err=1, no mem_we; write 0x0001 with parity bit 1 → mem_we=1.
